softmax_stream_tx_16: RTL and testbench
=======================================

// Module: softmax_stream_tx_16
// PURPOSE
//  - Feeds the softmax core. Collects a vector of scalar Q-format samples on a simple
//    valid/ready write port, stores the whole vector, then sends it as an AXI4-Stream master.
//  - Each output beat packs two samples: {odd element, even element}. TLAST marks the final beat.
//  - The output drives the core's slave port (s_axis_*), which consumes 2*DATA_SIZE pairs.
// PARAMETERS
//  - DATA_SIZE  16   width of one sample; beat width is 2*DATA_SIZE
//  - ADDR_W     7    buffer address width
//  - MAX_LEN    128  buffer depth in samples; must equal 2**ADDR_W and be <= 256
// PORTS
//  - axi_clock_i     in   1             single clock; all logic on its rising edge
//  - axi_reset_i     in   1             reset, synchronous, active-high
//  - wr_valid_i      in   1             sample valid
//  - wr_data_i       in   DATA_SIZE     sample
//  - wr_last_i       in   1             sample is the final element of the vector
//  - wr_ready_o      out  1             block accepts a sample (high only in FILL)
//  - m_axis_ready_i  in   1             downstream ready
//  - m_axis_data_o   out  2*DATA_SIZE   {elem[2k+1], elem[2k]}
//  - m_axis_valid_o  out  1             beat valid
//  - m_axis_last_o   out  1             final beat of the vector
//  - tx_busy_o       out  1             high while in SEND
//  - tx_len_o        out  ADDR_W+1      latched vector length (1..MAX_LEN)
// BEHAVIOUR
//  - Reset: state=FILL, wptr=0, rptr=0. m_axis_valid_o, m_axis_last_o and m_axis_data_o are 0.
//    tx_busy_o=0, tx_len_o=0. wr_ready_o=0 while axi_reset_i=1; it is 1 in the first cycle after.
//  - Reset mid-vector (either state): the partial vector is discarded. There is no partial beat
//    and no TLAST. After reset the block is in FILL and empty.
//  - FILL:
//    - wr_ready_o=1. On each handshake: buf[wptr]<=wr_data_i, wptr<=wptr+1.
//    - The handshake with wr_last_i=1, or the one at wptr==MAX_LEN-1 (forced end), latches
//      tx_len_o=wptr+1 and moves to SEND.
//  - SEND:
//    - wr_ready_o=0; wr_valid_i is ignored.
//    - Beats = ceil(len/2); rptr indexes the pair.
//    - Registered outputs. In the cycle after the final write handshake, m_axis_valid_o=1
//      and beat 0 is presented, so latency from last write to first beat is 1 cycle.
//    - While valid=1 and ready=0, data, valid and last hold stable.
//    - On each valid&ready handshake the next beat loads in the following cycle, so
//      back-to-back beats run at 1 beat/cycle.
//    - m_axis_last_o=1 only on beat ceil(len/2)-1.
//    - Handshake of the last beat: the next cycle has valid=0 and last=0, state=FILL,
//      wptr=0, rptr=0. No write handshake happens in that same cycle.
//  - Odd len: the upper half of the last beat is the pad value. The pad is 0 by default;
//    see CONFIGURATION. len=1 gives one beat with last=1.
//  - Even len: no pad, and the last beat holds elements len-2 and len-1.
//  - Buffer: register array, combinational read; write and read never overlap, per state.
//  - tx_len_o holds its value until the next vector's last write.
//  - tx_busy_o=(state==SEND).
// CONFIGURATION
//  - SOFTMAX_TX_PAD_MIN_EN defined: the odd-length pad is the most-negative value,
//    {1'b1,{DATA_SIZE-1{1'b0}}} (16'h8000). Its exp is about 0, so the pad does not
//    distort the softmax sum.
//  - SOFTMAX_TX_PAD_MIN_EN undefined: the pad is all zeros.
// TESTING
//  - Write 4 samples 0x0001..0x0004, last on the 4th, ready=1 -> beats 0x00020001 and
//    0x00040003 on consecutive cycles; last on beat 1; first valid 1 cycle after the 4th write.
//  - Write 3 samples 0x1111, 0x2222, 0x3333 -> beats 0x22221111, then 0x00003333
//    (0x80003333 with SOFTMAX_TX_PAD_MIN_EN) with last=1.
//  - Single sample 0x00AB -> one beat 0x000000AB (or 0x800000AB), last=1, tx_len_o=1.
//  - 6 samples; ready low 3 cycles on beat 1 -> beat 1 held unchanged; 3 beats total;
//    wr_ready_o=0 throughout SEND.
//  - Write MAX_LEN samples with no last -> forced end, tx_len_o=MAX_LEN, MAX_LEN/2 beats,
//    last on the final beat.
//  - Assert reset after 2 of 3 beats -> valid=0 next cycle, no last; the next vector of
//    2 samples transmits correctly.

Source files
------------

// File: rtl/softmax_stream_tx_16.sv
// Buffers one vector of scalar samples, then streams it as {odd, even} pairs on AXI4-Stream (TLAST on final beat).
// Latency: first beat registered 1 cycle after the final write; 1 beat/cycle while ready. Odd-length pad set by SOFTMAX_TX_PAD_MIN_EN.
// Backpressure: outputs hold while valid & !ready; writes are refused (wr_ready_o=0) for the whole send phase.
module softmax_stream_tx_16 #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_W    = 7,
    parameter int MAX_LEN   = 128
) (
    input  logic                   axi_clock_i,
    input  logic                   axi_reset_i,
    input  logic                   wr_valid_i,
    input  logic [DATA_SIZE-1:0]   wr_data_i,
    input  logic                   wr_last_i,
    output logic                   wr_ready_o,
    input  logic                   m_axis_ready_i,
    output logic [2*DATA_SIZE-1:0] m_axis_data_o,
    output logic                   m_axis_valid_o,
    output logic                   m_axis_last_o,
    output logic                   tx_busy_o,
    output logic [ADDR_W:0]        tx_len_o
);

`ifdef SOFTMAX_TX_PAD_MIN_EN
    localparam logic [DATA_SIZE-1:0] PAD = {1'b1, {(DATA_SIZE-1){1'b0}}};
`else
    localparam logic [DATA_SIZE-1:0] PAD = '0;
`endif

    typedef enum logic {FILL, SEND} state_t;

    state_t                 state, state_n;
    logic [ADDR_W-1:0]      wptr, wptr_n;
    logic [ADDR_W-2:0]      rptr, rptr_n, load_pair;
    logic [ADDR_W:0]        len_n, load_len, beats_m1;
    logic                   valid_n, last_n, load;
    logic [2*DATA_SIZE-1:0] data_n;
    logic [ADDR_W-1:0]      lo_idx, hi_idx;
    logic [DATA_SIZE-1:0]   lo_val, hi_val;
    logic                   wr_hs, ax_hs;
    logic [DATA_SIZE-1:0]   mem [MAX_LEN];

    assign wr_ready_o = (state == FILL) && !axi_reset_i;
    assign wr_hs      = wr_valid_i && wr_ready_o;
    assign ax_hs      = m_axis_valid_o && m_axis_ready_i;
    assign tx_busy_o  = (state == SEND);

    always_ff @(posedge axi_clock_i) begin
        if (wr_hs)
            mem[wptr] <= wr_data_i;
    end

    always_comb begin
        state_n   = state;
        wptr_n    = wptr;
        rptr_n    = rptr;
        len_n     = tx_len_o;
        valid_n   = m_axis_valid_o;
        last_n    = m_axis_last_o;
        data_n    = m_axis_data_o;
        load      = 1'b0;
        load_pair = rptr;
        load_len  = tx_len_o;

        case (state)
            FILL: begin
                if (wr_hs) begin
                    wptr_n = wptr + 1'b1;
                    if (wr_last_i || wptr == ADDR_W'(MAX_LEN - 1)) begin
                        len_n     = {1'b0, wptr} + 1'b1;
                        load_len  = len_n;
                        load_pair = '0;
                        load      = 1'b1;
                        state_n   = SEND;
                    end
                end
            end
            SEND: begin
                if (ax_hs) begin
                    if (m_axis_last_o) begin
                        state_n = FILL;
                        wptr_n  = '0;
                        rptr_n  = '0;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                    end else begin
                        rptr_n    = rptr + 1'b1;
                        load_pair = rptr_n;
                        load      = 1'b1;
                    end
                end
            end
        endcase

        // Beat 0 is built in the same cycle as the final write, so forward that write.
        lo_idx = {load_pair, 1'b0};
        hi_idx = {load_pair, 1'b1};
        lo_val = (wr_hs && lo_idx == wptr) ? wr_data_i : mem[lo_idx];
        hi_val = (wr_hs && hi_idx == wptr) ? wr_data_i : mem[hi_idx];
        if ({1'b0, hi_idx} >= load_len)
            hi_val = PAD;
        beats_m1 = (load_len - 1'b1) >> 1;

        if (load) begin
            data_n  = {hi_val, lo_val};
            valid_n = 1'b1;
            last_n  = ({2'b00, load_pair} == beats_m1);
        end
    end

    always_ff @(posedge axi_clock_i) begin
        if (axi_reset_i) begin
            state          <= FILL;
            wptr           <= '0;
            rptr           <= '0;
            tx_len_o       <= '0;
            m_axis_valid_o <= 1'b0;
            m_axis_last_o  <= 1'b0;
            m_axis_data_o  <= '0;
        end else begin
            state          <= state_n;
            wptr           <= wptr_n;
            rptr           <= rptr_n;
            tx_len_o       <= len_n;
            m_axis_valid_o <= valid_n;
            m_axis_last_o  <= last_n;
            m_axis_data_o  <= data_n;
        end
    end

endmodule

// File: tb/tb_softmax_stream_tx_16.sv
// Scoreboard bench: the writer queues the expected beats of each vector, a negedge monitor pops and compares
// every accepted beat and checks hold-under-backpressure and write refusal while sending.
module tb_softmax_stream_tx_16;

    localparam int MAX_LEN = 128;
`ifdef SOFTMAX_TX_PAD_MIN_EN
    localparam logic [15:0] PAD = 16'h8000;
`else
    localparam logic [15:0] PAD = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst, wr_valid, wr_last, m_ready;
    logic [15:0] wr_data;
    logic        wr_ready, m_valid, m_last, tx_busy;
    logic [31:0] m_data;
    logic [7:0]  tx_len;

    int n_checks = 0;
    int n_fail   = 0;
    int beats_seen = 0;
    logic [32:0] exp_q[$];

    softmax_stream_tx_16 dut (
        .axi_clock_i    (clk),
        .axi_reset_i    (rst),
        .wr_valid_i     (wr_valid),
        .wr_data_i      (wr_data),
        .wr_last_i      (wr_last),
        .wr_ready_o     (wr_ready),
        .m_axis_ready_i (m_ready),
        .m_axis_data_o  (m_data),
        .m_axis_valid_o (m_valid),
        .m_axis_last_o  (m_last),
        .tx_busy_o      (tx_busy),
        .tx_len_o       (tx_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [32:0] e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_valid), 64'(1));
                check("hold_data", 64'(m_data), 64'(prev_data));
                check("hold_last", 64'(m_last), 64'(prev_last));
            end
            if (tx_busy)
                check("wr_ready_in_send", 64'(wr_ready), 64'(0));
            if (m_valid && m_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%08h last=%0b, none expected", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(m_data), 64'(e[31:0]));
                    check("beat_last", 64'(m_last), 64'(e[32]));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Reference model: pair up samples, pad an odd tail, last on the final pair.
    task automatic write_vec(input logic [15:0] s[$], input bit force_end);
        int n  = s.size();
        int nb = (n + 1) / 2;
        logic [15:0] lo, hi;
        for (int k = 0; k < nb; k++) begin
            lo = s[2*k];
            hi = (2*k + 1 < n) ? s[2*k+1] : PAD;
            exp_q.push_back({(k == nb - 1), hi, lo});
        end
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = s[i];
            wr_last  = !force_end && (i == n - 1);
            @(negedge clk);
            check("wr_ready_fill", 64'(wr_ready), 64'(1));
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        @(negedge clk);
        check("first_beat_latency", 64'(m_valid), 64'(1));
        check("busy_in_send", 64'(tx_busy), 64'(1));
        check("tx_len", 64'(tx_len), 64'(n));
    endtask

    task automatic drain(input int pct, input int n_len);
        bit done = 1'b0;
        int cyc  = 0;
        while (!done && cyc < 4000) begin
            m_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            if (!tx_busy && !m_valid && exp_q.size() == 0)
                done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
            cyc++;
        end
        check("drain_complete", 64'(done), 64'(1));
        check("idle_valid", 64'(m_valid), 64'(0));
        check("idle_last", 64'(m_last), 64'(0));
        check("tx_len_held", 64'(tx_len), 64'(n_len));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v[$];
        int b0, len, pct;
        bit fe;

        rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(m_valid), 64'(0));
        check("rst_last", 64'(m_last), 64'(0));
        check("rst_data", 64'(m_data), 64'(0));
        check("rst_busy", 64'(tx_busy), 64'(0));
        check("rst_len", 64'(tx_len), 64'(0));
        check("rst_wr_ready", 64'(wr_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("wr_ready_after_rst", 64'(wr_ready), 64'(1));
        @(posedge clk);
        #1;

        // Four samples, even length
        m_ready = 1'b1;
        v = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        write_vec(v, 1'b0);
        drain(100, 4);

        // Odd length pads the upper half
        v = '{16'h1111, 16'h2222, 16'h3333};
        write_vec(v, 1'b0);
        drain(100, 3);

        // Single sample
        v = '{16'h00AB};
        write_vec(v, 1'b0);
        drain(100, 1);

        // Backpressure on beat 1 for three cycles
        b0 = beats_seen;
        m_ready = 1'b1;
        v = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
        write_vec(v, 1'b0);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drain(100, 6);
        check("beats_len6", 64'(beats_seen - b0), 64'(3));

        // Full buffer with no last marker
        b0 = beats_seen;
        v = {};
        for (int i = 0; i < MAX_LEN; i++) v.push_back(16'($urandom));
        write_vec(v, 1'b1);
        drain(100, MAX_LEN);
        check("beats_forced", 64'(beats_seen - b0), 64'(MAX_LEN / 2));

        // Reset after two of three beats
        b0 = beats_seen;
        m_ready = 1'b1;
        v = '{16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005};
        write_vec(v, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 64'(m_valid), 64'(0));
        check("midrst_last", 64'(m_last), 64'(0));
        check("midrst_busy", 64'(tx_busy), 64'(0));
        check("midrst_beats", 64'(beats_seen - b0), 64'(2));
        check("midrst_pending", 64'(exp_q.size()), 64'(1));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        v = '{16'hC001, 16'hC002};
        write_vec(v, 1'b0);
        drain(100, 2);

        // Random vectors with random backpressure
        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(MAX_LEN, 1);
            fe  = (len == MAX_LEN) ? 1'($urandom_range(1, 0)) : 1'b0;
            pct = $urandom_range(100, 30);
            v = {};
            for (int i = 0; i < len; i++) v.push_back(16'($urandom));
            m_ready = ($urandom_range(99) < pct);
            write_vec(v, fe);
            drain(pct, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
